test_receiver: RTL and testbench

Loopback checker for the raw-Ethernet test traffic stream (EtherType 0x88B5). It sits on the receive side of the Ethernet frame interface, downstream of the MAC/eth_axis_rx parser. It accepts decoded headers and payload, filters on destination MAC and EtherType, and checks that every accepted frame carries LENGTH bytes of a mod-256 incrementing byte pattern. Per-frame results go into debug-visible 32-bit counters.

---
 rtl/test_receiver.sv | 224 ++++++++++++++++++++++
 tb/tb_test_receiver.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_receiver.sv
// test_receiver: receive-side checker for the 0x88B5 raw-Ethernet test stream.
// Frames are filtered on destination MAC and EtherType. Each accepted frame is
// checked for a mod-256 incrementing byte pattern, for its length, and for
// continuity with the previous accepted frame. Results go into 32-bit counters.
module test_receiver #(
    parameter int          LENGTH      = 512,
    parameter logic [47:0] LOCAL_MAC   = 48'h02_00_00_00_00_00,
    parameter logic [15:0] EXPECT_TYPE = 16'h88B5,
    parameter int          DATA_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  s_eth_hdr_valid,
    output logic                  s_eth_hdr_ready,
    input  logic [47:0]           s_eth_dest_mac,
    input  logic [47:0]           s_eth_src_mac,
    input  logic [15:0]           s_eth_type,
    input  logic [DATA_WIDTH-1:0] s_eth_payload_axis_tdata,
    input  logic                  s_eth_payload_axis_tvalid,
    output logic                  s_eth_payload_axis_tready,
    input  logic                  s_eth_payload_axis_tlast,
    input  logic                  s_eth_payload_axis_tuser,
    output logic [31:0]           frame_count,
    output logic [31:0]           good_count,
    output logic [31:0]           drop_count,
    output logic [31:0]           data_err_count,
    output logic [31:0]           len_err_count,
    output logic [31:0]           seq_err_count,
    output logic [31:0]           bad_count,
    output logic [47:0]           last_src_mac,
    output logic                  frame_done,
    output logic                  frame_ok
);

    localparam logic [15:0] LEN16     = 16'(LENGTH);
    localparam logic [47:0] BCAST_MAC = 48'hFF_FF_FF_FF_FF_FF;
    localparam int          NUM_CNT   = 7;

    // counter slots
    localparam int C_FRAME = 0;
    localparam int C_GOOD  = 1;
    localparam int C_DROP  = 2;
    localparam int C_DATA  = 3;
    localparam int C_LEN   = 4;
    localparam int C_SEQ   = 5;
    localparam int C_BAD   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t      state_reg;
    logic        hdr_ready_reg;
    logic        tready_reg;
    logic [15:0] beat_cnt_reg;
    logic [7:0]  prev_byte_reg;
    logic        data_err_reg;
    logic        seq_err_reg;
    logic        frame_done_reg;
    logic        frame_ok_reg;

    logic        have_prev_reg;
    logic [7:0]  prev_frame_last_reg;
    logic [47:0] last_src_mac_reg;

    logic [31:0] cnt_reg [NUM_CNT];
    logic [NUM_CNT-1:0] cnt_inc;

    logic        hdr_fire;
    logic        beat_fire;
    logic        hdr_match;
    logic        first_beat;
    logic [7:0]  byte_in;
    logic [15:0] beats_next;
    logic        seq_final;
    logic        data_final;
    logic        len_final;
    logic        ok_final;
    logic        recv_last;
    logic        drop_last;

    assign s_eth_hdr_ready           = hdr_ready_reg;
    assign s_eth_payload_axis_tready = tready_reg;
    assign frame_done                = frame_done_reg;
    assign frame_ok                  = frame_ok_reg;
    assign last_src_mac              = last_src_mac_reg;

    assign frame_count    = cnt_reg[C_FRAME];
    assign good_count     = cnt_reg[C_GOOD];
    assign drop_count     = cnt_reg[C_DROP];
    assign data_err_count = cnt_reg[C_DATA];
    assign len_err_count  = cnt_reg[C_LEN];
    assign seq_err_count  = cnt_reg[C_SEQ];
    assign bad_count      = cnt_reg[C_BAD];

    // Handshakes and the per-frame check results for the beat being consumed.
    // The final flags fold in the current beat so a tlast beat is judged
    // together with everything that came before it.
    always_comb begin
        hdr_fire   = s_eth_hdr_valid && hdr_ready_reg;
        beat_fire  = s_eth_payload_axis_tvalid && tready_reg;
        hdr_match  = ((s_eth_dest_mac == LOCAL_MAC) || (s_eth_dest_mac == BCAST_MAC)) &&
                     (s_eth_type == EXPECT_TYPE);
        first_beat = (beat_cnt_reg == 16'd0);
        byte_in    = s_eth_payload_axis_tdata[7:0];
        beats_next = (beat_cnt_reg == 16'hFFFF) ? 16'hFFFF : beat_cnt_reg + 16'd1;
        seq_final  = first_beat ? (have_prev_reg && (byte_in != prev_frame_last_reg + 8'd1))
                                : seq_err_reg;
        data_final = data_err_reg || (!first_beat && (byte_in != prev_byte_reg + 8'd1));
        len_final  = (beats_next != LEN16);
        ok_final   = !(seq_final || data_final || len_final || s_eth_payload_axis_tuser);
        recv_last  = (state_reg == RECV) && beat_fire && s_eth_payload_axis_tlast;
        drop_last  = (state_reg == DROP) && beat_fire && s_eth_payload_axis_tlast;
    end

    // Frame FSM with registered ready outputs and per-frame check state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            hdr_ready_reg  <= 1'b1;
            tready_reg     <= 1'b0;
            beat_cnt_reg   <= 16'd0;
            prev_byte_reg  <= 8'd0;
            data_err_reg   <= 1'b0;
            seq_err_reg    <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_ok_reg   <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            frame_ok_reg   <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (hdr_fire) begin
                        beat_cnt_reg  <= 16'd0;
                        data_err_reg  <= 1'b0;
                        seq_err_reg   <= 1'b0;
                        hdr_ready_reg <= 1'b0;
                        tready_reg    <= 1'b1;
                        state_reg     <= hdr_match ? RECV : DROP;
                    end
                end
                RECV: begin
                    if (beat_fire) begin
                        beat_cnt_reg  <= beats_next;
                        prev_byte_reg <= byte_in;
                        data_err_reg  <= data_final;
                        seq_err_reg   <= seq_final;
                        if (s_eth_payload_axis_tlast) begin
                            frame_done_reg <= 1'b1;
                            frame_ok_reg   <= ok_final;
                            hdr_ready_reg  <= 1'b1;
                            tready_reg     <= 1'b0;
                            state_reg      <= IDLE;
                        end
                    end
                end
                DROP: begin
                    if (drop_last) begin
                        hdr_ready_reg <= 1'b1;
                        tready_reg    <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    hdr_ready_reg <= 1'b1;
                    tready_reg    <= 1'b0;
                    state_reg     <= IDLE;
                end
            endcase
        end
    end

    // Cross-frame state: last accepted source MAC and the sequence anchor.
    // A clear takes priority over a header or frame completing the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_prev_reg       <= 1'b0;
            prev_frame_last_reg <= 8'd0;
            last_src_mac_reg    <= 48'd0;
        end else if (clr) begin
            have_prev_reg       <= 1'b0;
            last_src_mac_reg    <= 48'd0;
        end else begin
            if (hdr_fire && hdr_match) begin
                last_src_mac_reg <= s_eth_src_mac;
            end
            if (recv_last) begin
                have_prev_reg       <= 1'b1;
                prev_frame_last_reg <= byte_in;
            end
        end
    end

    // Increment requests for each result counter.
    always_comb begin
        cnt_inc          = '0;
        cnt_inc[C_FRAME] = recv_last;
        cnt_inc[C_GOOD]  = recv_last && ok_final;
        cnt_inc[C_DROP]  = drop_last;
        cnt_inc[C_DATA]  = recv_last && data_final;
        cnt_inc[C_LEN]   = recv_last && len_final;
        cnt_inc[C_SEQ]   = recv_last && seq_final;
        cnt_inc[C_BAD]   = recv_last && s_eth_payload_axis_tuser;
    end

    // Wrapping 32-bit result counters; clear wins over a same-cycle increment.
    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= 32'd0;
                end else if (clr) begin
                    cnt_reg[gi] <= 32'd0;
                end else if (cnt_inc[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 32'd1;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_test_receiver.sv
// Directed bench for test_receiver with LENGTH=16: a table of frames with
// hand-computed cumulative counter values, then clear and reset corner cases.
`timescale 1ns/1ps
module tb_test_receiver;

    localparam logic [47:0] LMAC  = 48'h02_00_00_00_00_00;
    localparam logic [47:0] OMAC  = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BMAC  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [47:0] SRC0  = 48'h0A_00_00_00_00_00;
    localparam int          NVEC  = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        hdr_valid = 1'b0;
    logic        hdr_ready;
    logic [47:0] dest_mac = '0;
    logic [47:0] src_mac = '0;
    logic [15:0] eth_type = '0;
    logic [7:0]  tdata = '0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        tlast = 1'b0;
    logic        tuser = 1'b0;
    logic [31:0] frame_count, good_count, drop_count, data_err_count;
    logic [31:0] len_err_count, seq_err_count, bad_count;
    logic [47:0] last_src_mac;
    logic        frame_done, frame_ok;

    int n_vec = 0;
    int n_err = 0;

    always #4 clk = ~clk;

    test_receiver #(
        .LENGTH(16)
    ) dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .clr                       (clr),
        .s_eth_hdr_valid           (hdr_valid),
        .s_eth_hdr_ready           (hdr_ready),
        .s_eth_dest_mac            (dest_mac),
        .s_eth_src_mac             (src_mac),
        .s_eth_type                (eth_type),
        .s_eth_payload_axis_tdata  (tdata),
        .s_eth_payload_axis_tvalid (tvalid),
        .s_eth_payload_axis_tready (tready),
        .s_eth_payload_axis_tlast  (tlast),
        .s_eth_payload_axis_tuser  (tuser),
        .frame_count               (frame_count),
        .good_count                (good_count),
        .drop_count                (drop_count),
        .data_err_count            (data_err_count),
        .len_err_count             (len_err_count),
        .seq_err_count             (seq_err_count),
        .bad_count                 (bad_count),
        .last_src_mac              (last_src_mac),
        .frame_done                (frame_done),
        .frame_ok                  (frame_ok)
    );

    typedef struct {
        logic [47:0] dest;
        logic [15:0] etype;
        logic [7:0]  start;
        int          n;
        int          cidx;
        logic [7:0]  cval;
        logic        tu;
        logic        gap;
        logic        exp_done;
        logic        exp_ok;
        int          f, g, d, de, le, se, b;
        int          src_idx;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_counts(input string tag, input int f, input int g, input int d,
                              input int de, input int le, input int se, input int b);
        chk({tag, ".frame_count"},    64'(frame_count),    64'(f));
        chk({tag, ".good_count"},     64'(good_count),     64'(g));
        chk({tag, ".drop_count"},     64'(drop_count),     64'(d));
        chk({tag, ".data_err_count"}, 64'(data_err_count), 64'(de));
        chk({tag, ".len_err_count"},  64'(len_err_count),  64'(le));
        chk({tag, ".seq_err_count"},  64'(seq_err_count),  64'(se));
        chk({tag, ".bad_count"},      64'(bad_count),      64'(b));
    endtask

    // Present a header and hold it until accepted (bounded).
    task automatic send_header(input string tag, input logic [47:0] dest,
                               input logic [15:0] etype, input logic [47:0] src);
        int waited;
        dest_mac  = dest;
        eth_type  = etype;
        src_mac   = src;
        hdr_valid = 1'b1;
        waited    = 0;
        while (!hdr_ready && waited < 50) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!hdr_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL %s.hdr_wait: got hdr_ready=0 expected 1 within 50 cycles", tag);
        end
        @(posedge clk);
        #1;
        hdr_valid = 1'b0;
    endtask

    // Send a full frame; returns what the DUT showed around the tlast beat.
    task automatic send_frame(input string tag, input logic [47:0] dest, input logic [15:0] etype,
                              input logic [47:0] src, input logic [7:0] start, input int n,
                              input int cidx, input logic [7:0] cval, input logic tu,
                              input logic gap, input logic clr_last,
                              output logic got_done, output logic got_ok,
                              output logic tready_held, output logic hdr_after,
                              output logic done_after);
        int i;
        int guard;
        logic [7:0] b;
        send_header(tag, dest, etype, src);
        i = 0;
        guard = 0;
        tready_held = 1'b1;
        got_done = 1'b0;
        got_ok = 1'b0;
        hdr_after = 1'b0;
        while (i < n && guard < 2000) begin
            guard++;
            if (gap && ($urandom_range(0, 1) == 0)) begin
                tvalid = 1'b0;
                tlast  = 1'b0;
                clr    = 1'b0;
            end else begin
                b = start + 8'(i);
                if (i == cidx) b = cval;
                tdata  = b;
                tvalid = 1'b1;
                tlast  = (i == n - 1);
                tuser  = tlast ? tu : 1'b0;
                clr    = tlast && clr_last;
            end
            if (!tready) tready_held = 1'b0;
            @(posedge clk);
            #1;
            if (tvalid) begin
                if (tlast) begin
                    got_done  = frame_done;
                    got_ok    = frame_ok;
                    hdr_after = hdr_ready;
                end
                i++;
            end
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
        tuser  = 1'b0;
        clr    = 1'b0;
        @(posedge clk);
        #1;
        done_after = frame_done;
        $display("frame %s: start=%0h beats=%0d done=%0b ok=%0b frames=%0d good=%0d drop=%0d",
                 tag, start, n, got_done, got_ok, frame_count, good_count, drop_count);
    endtask

    initial begin
        logic gd, go, th, ha, da;
        // dest, type, start, n, cidx, cval, tuser, gap, done, ok, f,g,d,de,le,se,b, src_idx
        vecs[0]  = '{LMAC, 16'h88B5, 8'h00, 16, -1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1,  1, 1, 0, 0, 0, 0, 0,  0};
        vecs[1]  = '{LMAC, 16'h88B5, 8'h10, 16, -1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1,  2, 2, 0, 0, 0, 0, 0,  1};
        vecs[2]  = '{LMAC, 16'h88B5, 8'h20, 16, -1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1,  3, 3, 0, 0, 0, 0, 0,  2};
        vecs[3]  = '{OMAC, 16'h88B5, 8'h30, 16, -1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,  3, 3, 1, 0, 0, 0, 0,  2};
        vecs[4]  = '{LMAC, 16'h0800, 8'h30, 16, -1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0,  3, 3, 2, 0, 0, 0, 0,  2};
        vecs[5]  = '{LMAC, 16'h88B5, 8'h30, 16,  5, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0,  4, 3, 2, 1, 0, 0, 0,  5};
        vecs[6]  = '{LMAC, 16'h88B5, 8'h40, 15, -1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,  5, 3, 2, 1, 1, 0, 0,  6};
        vecs[7]  = '{LMAC, 16'h88B5, 8'h4F, 17, -1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,  6, 3, 2, 1, 2, 0, 0,  7};
        vecs[8]  = '{LMAC, 16'h88B5, 8'h63, 16, -1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0,  7, 3, 2, 1, 2, 1, 0,  8};
        vecs[9]  = '{LMAC, 16'h88B5, 8'h73, 16, -1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0,  8, 3, 2, 1, 2, 1, 1,  9};
        vecs[10] = '{LMAC, 16'h88B5, 8'h83, 16, -1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1,  9, 4, 2, 1, 2, 1, 1, 10};
        vecs[11] = '{BMAC, 16'h88B5, 8'h93, 16, -1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 10, 5, 2, 1, 2, 1, 1, 11};
        vecs[12] = '{LMAC, 16'h88B5, 8'hA3,  1, -1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 11, 5, 2, 1, 3, 1, 1, 12};
        vecs[13] = '{LMAC, 16'h88B5, 8'hA4, 16, -1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 12, 6, 2, 1, 3, 1, 1, 13};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset.hdr_ready", 64'(hdr_ready), 64'd1);
        chk("reset.tready", 64'(tready), 64'd0);
        chk("reset.frame_done", 64'(frame_done), 64'd0);
        chk("reset.frame_ok", 64'(frame_ok), 64'd0);
        chk("reset.last_src_mac", 64'(last_src_mac), 64'd0);
        chk_counts("reset", 0, 0, 0, 0, 0, 0, 0);

        // Table-driven frames
        for (int i = 0; i < NVEC; i++) begin
            string tag;
            tag = $sformatf("v%0d", i);
            send_frame(tag, vecs[i].dest, vecs[i].etype, SRC0 + 48'(i), vecs[i].start, vecs[i].n,
                       vecs[i].cidx, vecs[i].cval, vecs[i].tu, vecs[i].gap, 1'b0,
                       gd, go, th, ha, da);
            chk({tag, ".frame_done"}, 64'(gd), 64'(vecs[i].exp_done));
            if (vecs[i].exp_done) chk({tag, ".frame_ok"}, 64'(go), 64'(vecs[i].exp_ok));
            chk({tag, ".tready_held"}, 64'(th), 64'd1);
            chk({tag, ".hdr_ready_after_tlast"}, 64'(ha), 64'd1);
            chk({tag, ".frame_done_one_cycle"}, 64'(da), 64'd0);
            chk({tag, ".last_src_mac"}, 64'(last_src_mac), 64'(SRC0 + 48'(vecs[i].src_idx)));
            chk_counts(tag, vecs[i].f, vecs[i].g, vecs[i].d, vecs[i].de,
                       vecs[i].le, vecs[i].se, vecs[i].b);
        end

        // clr coinciding with the tlast fire: frame not counted, pulse still seen
        send_frame("clr_tlast", LMAC, 16'h88B5, SRC0 + 48'h20, 8'hB4, 16, -1, 8'h00,
                   1'b0, 1'b0, 1'b1, gd, go, th, ha, da);
        chk("clr_tlast.frame_done", 64'(gd), 64'd1);
        chk("clr_tlast.frame_ok", 64'(go), 64'd1);
        chk("clr_tlast.last_src_mac", 64'(last_src_mac), 64'd0);
        chk_counts("clr_tlast", 0, 0, 0, 0, 0, 0, 0);

        // After clr there is no previous frame, so an arbitrary start is not a seq error
        send_frame("after_clr", LMAC, 16'h88B5, SRC0 + 48'h21, 8'h50, 16, -1, 8'h00,
                   1'b0, 1'b0, 1'b0, gd, go, th, ha, da);
        chk("after_clr.frame_ok", 64'(go), 64'd1);
        chk("after_clr.last_src_mac", 64'(last_src_mac), 64'(SRC0 + 48'h21));
        chk_counts("after_clr", 1, 1, 0, 0, 0, 0, 0);

        // Reset asserted mid-payload
        send_header("rst_mid", LMAC, 16'h88B5, SRC0 + 48'h30);
        for (int i = 0; i < 5; i++) begin
            tdata  = 8'h60 + 8'(i);
            tvalid = 1'b1;
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        chk("rst_mid.hdr_ready", 64'(hdr_ready), 64'd1);
        chk("rst_mid.tready", 64'(tready), 64'd0);
        chk("rst_mid.last_src_mac", 64'(last_src_mac), 64'd0);
        chk_counts("rst_mid", 0, 0, 0, 0, 0, 0, 0);
        $display("frame rst_mid: reset after 5 beats hdr_ready=%0b tready=%0b", hdr_ready, tready);
        tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // A fresh good frame after reset, arbitrary start byte
        send_frame("after_rst", LMAC, 16'h88B5, SRC0 + 48'h31, 8'h77, 16, -1, 8'h00,
                   1'b0, 1'b0, 1'b0, gd, go, th, ha, da);
        chk("after_rst.frame_done", 64'(gd), 64'd1);
        chk("after_rst.frame_ok", 64'(go), 64'd1);
        chk_counts("after_rst", 1, 1, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
